// File: rtl/axi_lsu_if.sv
// Data-side AXI4-Lite channel bundle between the load/store engine and the interconnect.
// Suffixes follow the master's view: _o driven by the master, _i driven by the slave.
interface axi_lsu_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr_o;
  logic              arvalid_o;
  logic              arready_i;

  logic [DATA_W-1:0] rdata_i;
  logic [1:0]        rresp_i;
  logic              rvalid_i;
  logic              rready_o;

  logic [ADDR_W-1:0] awaddr_o;
  logic              awvalid_o;
  logic              awready_i;

  logic [DATA_W-1:0] wdata_o;
  logic [STRB_W-1:0] wstrb_o;
  logic              wvalid_o;
  logic              wready_i;

  logic [1:0]        bresp_i;
  logic              bvalid_i;
  logic              bready_o;

  modport master (
    output araddr_o, arvalid_o, rready_o,
    output awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
    input  arready_i, rdata_i, rresp_i, rvalid_i,
    input  awready_i, wready_i, bresp_i, bvalid_i
  );

  modport slave (
    input  araddr_o, arvalid_o, rready_o,
    input  awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
    output arready_i, rdata_i, rresp_i, rvalid_i,
    output awready_i, wready_i, bresp_i, bvalid_i
  );
endinterface

// File: rtl/axi_lsu_master.sv
// MEM-stage load/store engine: one outstanding AXI4-Lite read or write per access,
// with busy/busy_end handshakes to the hazard controller.
module axi_lsu_master #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic [DATA_W/8-1:0]   mem_wmask_i,
  output logic [DATA_W-1:0]     mem_rdata_o,
  output logic                  axi_busy_o,
  output logic                  axi_busy_end_o,
  output logic                  axi_err_o,
  axi_lsu_if.master             axi
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              aw_done;
  logic              w_done;

  logic ar_hs;
  logic r_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic aw_all;
  logic w_all;

  // Ready-qualified valids are only ever high in their own state, so the
  // handshakes double as state qualifiers for the completion outputs.
  assign ar_hs  = arvalid_q & axi.arready_i;
  assign r_hs   = rready_q  & axi.rvalid_i;
  assign aw_hs  = awvalid_q & axi.awready_i;
  assign w_hs   = wvalid_q  & axi.wready_i;
  assign b_hs   = bready_q  & axi.bvalid_i;
  assign aw_all = aw_done | aw_hs;
  assign w_all  = w_done  | w_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req_i) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            wmask_q <= mem_wmask_i;
            if (mem_we_i) begin
              state     <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
            end else begin
              state     <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            rready_q <= 1'b0;
            rdata_q  <= axi.rdata_i;
            state    <= IDLE;
          end
        end
        WR_REQ: begin
          // AW and W complete independently; a same-cycle final handshake still moves on.
          if (aw_all && w_all) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            bready_q  <= 1'b1;
            state     <= WR_RESP;
          end else begin
            if (aw_hs) begin
              aw_done   <= 1'b1;
              awvalid_q <= 1'b0;
            end
            if (w_hs) begin
              w_done   <= 1'b1;
              wvalid_q <= 1'b0;
            end
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign axi.araddr_o  = addr_q;
  assign axi.arvalid_o = arvalid_q;
  assign axi.rready_o  = rready_q;
  assign axi.awaddr_o  = addr_q;
  assign axi.awvalid_o = awvalid_q;
  assign axi.wdata_o   = wdata_q;
  assign axi.wstrb_o   = wmask_q;
  assign axi.wvalid_o  = wvalid_q;
  assign axi.bready_o  = bready_q;

  // Busy rises in the request cycle itself so the pipeline stalls without a bubble.
  assign axi_busy_o     = (state != IDLE) | mem_req_i;
  assign axi_busy_end_o = r_hs | b_hs;
  assign axi_err_o      = (r_hs & (axi.rresp_i != 2'b00)) | (b_hs & (axi.bresp_i != 2'b00));
  assign mem_rdata_o    = r_hs ? axi.rdata_i : rdata_q;
endmodule

// File: tb/tb_axi_lsu_master.sv
// Directed bench for axi_lsu_master: a delay-programmable AXI4-Lite slave plus a table
// of load/store vectors, followed by a mid-read reset sequence.
module tb_axi_lsu_master;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              busy_end;
  logic              err;

  always #5 clk = ~clk;

  axi_lsu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_lsu_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_i      (mem_req),
    .mem_we_i       (mem_we),
    .mem_addr_i     (mem_addr),
    .mem_wdata_i    (mem_wdata),
    .mem_wmask_i    (mem_wmask),
    .mem_rdata_o    (mem_rdata),
    .axi_busy_o     (busy),
    .axi_busy_end_o (busy_end),
    .axi_err_o      (err),
    .axi            (bus.master)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          ar_dly;
    int          r_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [63:0] rdata;
    logic [1:0]  resp;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [7];
  int          total = 0;
  int          bad = 0;
  logic [63:0] prev_held;

  int          cfg_ar_dly, cfg_r_dly, cfg_aw_dly, cfg_w_dly, cfg_b_dly;
  logic [63:0] cfg_rdata;
  logic [1:0]  cfg_resp;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;

  // Slave: each ready/valid rises after its programmed number of wait cycles.
  always @(negedge clk) begin
    if (rst) begin
      bus.arready_i = 1'b0; bus.rvalid_i = 1'b0; bus.awready_i = 1'b0;
      bus.wready_i  = 1'b0; bus.bvalid_i = 1'b0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      bus.rdata_i = cfg_rdata;
      bus.rresp_i = cfg_resp;
      bus.bresp_i = cfg_resp;
      if (bus.arvalid_o) begin bus.arready_i = (ar_cnt == cfg_ar_dly); ar_cnt++; end
      else begin bus.arready_i = 1'b0; ar_cnt = 0; end
      if (bus.rready_o) begin bus.rvalid_i = (r_cnt == cfg_r_dly); r_cnt++; end
      else begin bus.rvalid_i = 1'b0; r_cnt = 0; end
      if (bus.awvalid_o) begin bus.awready_i = (aw_cnt == cfg_aw_dly); aw_cnt++; end
      else begin bus.awready_i = 1'b0; aw_cnt = 0; end
      if (bus.wvalid_o) begin bus.wready_i = (w_cnt == cfg_w_dly); w_cnt++; end
      else begin bus.wready_i = 1'b0; w_cnt = 0; end
      if (bus.bready_o) begin bus.bvalid_i = (b_cnt == cfg_b_dly); b_cnt++; end
      else begin bus.bvalid_i = 1'b0; b_cnt = 0; end
    end
  end

  function automatic vec_t mkv(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] wmask, input int ar, input int r, input int aw,
                               input int w, input int b, input logic [63:0] rdata,
                               input logic [1:0] resp, input logic [63:0] exp_rdata,
                               input logic exp_err, input int exp_lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
    v.ar_dly = ar; v.r_dly = r; v.aw_dly = aw; v.w_dly = w; v.b_dly = b;
    v.rdata = rdata; v.resp = resp;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Issues one request, then holds junk on the request inputs until completion.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   lat, arc, awc, wc, bc, viol;
    logic done;
    logic [63:0] end_rdata;
    logic end_err;
    cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly; cfg_aw_dly = v.aw_dly;
    cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly; cfg_rdata = v.rdata; cfg_resp = v.resp;
    @(negedge clk); #2;
    mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata; mem_wmask = v.wmask;
    #1;
    checkOutput({tag, "_req_busy"}, {63'd0, busy}, 64'd1);
    checkOutput({tag, "_req_noend"}, {63'd0, busy_end}, 64'd0);
    checkOutput({tag, "_req_novalid"}, {61'd0, bus.arvalid_o, bus.awvalid_o, bus.wvalid_o}, 64'd0);
    checkOutput({tag, "_req_rdata"}, mem_rdata, prev_held);
    lat = 1; arc = 0; awc = 0; wc = 0; bc = 0; viol = 0; done = 1'b0;
    end_rdata = '0; end_err = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk); #2;
      mem_req = 1'b1; mem_we = ~v.we; mem_addr = ~v.addr; mem_wdata = ~v.wdata; mem_wmask = ~v.wmask;
      #1;
      lat++;
      if (bus.arvalid_o) arc++;
      if (bus.awvalid_o) awc++;
      if (bus.wvalid_o) wc++;
      if (bus.bready_o) bc++;
      if (bus.arvalid_o && bus.awvalid_o) viol++;
      if (err && !busy_end) viol++;
      if (!busy) viol++;
      if (bus.bready_o && (bus.awvalid_o || bus.wvalid_o)) viol++;
      if (bus.arvalid_o && bus.araddr_o !== v.addr) viol++;
      if (bus.awvalid_o && bus.awaddr_o !== v.addr) viol++;
      if (bus.wvalid_o && (bus.wdata_o !== v.wdata || bus.wstrb_o !== v.wmask)) viol++;
      if (busy_end) begin
        done = 1'b1; end_rdata = mem_rdata; end_err = err;
      end
    end
    mem_req = 1'b0;
    checkOutput({tag, "_done"}, {63'd0, done}, 64'd1);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    checkOutput({tag, "_end_rdata"}, end_rdata, v.exp_rdata);
    checkOutput({tag, "_end_err"}, {63'd0, end_err}, {63'd0, v.exp_err});
    checkOutput({tag, "_protocol"}, 64'(viol), 64'd0);
    checkOutput({tag, "_ar_cycles"}, 64'(arc), v.we ? 64'd0 : 64'(v.ar_dly + 1));
    checkOutput({tag, "_aw_cycles"}, 64'(awc), v.we ? 64'(v.aw_dly + 1) : 64'd0);
    checkOutput({tag, "_w_cycles"}, 64'(wc), v.we ? 64'(v.w_dly + 1) : 64'd0);
    checkOutput({tag, "_b_cycles"}, 64'(bc), v.we ? 64'(v.b_dly + 1) : 64'd0);
    prev_held = v.exp_rdata;
  endtask

  task automatic idleCheck(input string tag);
    @(negedge clk); #3;
    checkOutput({tag, "_idle_busy"}, {62'd0, busy, busy_end}, 64'd0);
    checkOutput({tag, "_idle_rdata"}, mem_rdata, prev_held);
  endtask

  initial begin
    int pulses;
    logic seen;
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
    cfg_ar_dly = 0; cfg_r_dly = 0; cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0;
    cfg_rdata = '0; cfg_resp = 2'b00; prev_held = '0;
    bus.arready_i = 1'b0; bus.rvalid_i = 1'b0; bus.awready_i = 1'b0; bus.wready_i = 1'b0;
    bus.bvalid_i = 1'b0; bus.rdata_i = '0; bus.rresp_i = 2'b00; bus.bresp_i = 2'b00;

    //             we    addr                   wdata                  mask   ar r aw w b  rdata                  resp   exp_rdata              err lat
    vecs[0] = mkv(1'b0, 64'h0000_0000_8000_0010, 64'h0,                8'h00, 2, 3, 0, 0, 0, 64'hDEAD_BEEF_0123_4567, 2'd0, 64'hDEAD_BEEF_0123_4567, 1'b0, 8);
    vecs[1] = mkv(1'b1, 64'h0000_0000_8000_0020, 64'h1122_3344_5566_7788, 8'h0F, 0, 0, 0, 1, 1, 64'h0,                 2'd0, 64'hDEAD_BEEF_0123_4567, 1'b0, 5);
    vecs[2] = mkv(1'b1, 64'h0000_0000_8000_0030, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 0, 0, 0, 0, 0, 64'h0,                 2'd0, 64'hDEAD_BEEF_0123_4567, 1'b0, 3);
    vecs[3] = mkv(1'b0, 64'h0000_0000_8000_0040, 64'h0,                8'h00, 0, 0, 0, 0, 0, 64'h0BAD_F00D_0000_0001, 2'd2, 64'h0BAD_F00D_0000_0001, 1'b1, 3);
    vecs[4] = mkv(1'b1, 64'h0000_0000_8000_0048, 64'hCAFE_BABE_F00D_D00D, 8'hF0, 0, 0, 2, 0, 0, 64'h0,                 2'd3, 64'h0BAD_F00D_0000_0001, 1'b1, 5);
    vecs[5] = mkv(1'b1, 64'h0000_0000_8000_0050, 64'h0102_0304_0506_0708, 8'h3C, 0, 0, 1, 1, 0, 64'h0,                 2'd0, 64'h0BAD_F00D_0000_0001, 1'b0, 4);
    vecs[6] = mkv(1'b0, 64'h0000_0000_8000_0058, 64'h0,                8'h00, 0, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 3);

    repeat (3) @(negedge clk);
    #3;
    checkOutput("reset_valids", {59'd0, bus.arvalid_o, bus.rready_o, bus.awvalid_o, bus.wvalid_o, bus.bready_o}, 64'd0);
    checkOutput("reset_busy", {61'd0, busy, busy_end, err}, 64'd0);
    checkOutput("reset_rdata", mem_rdata, 64'd0);
    rst = 1'b0;

    // Each request is issued in the first idle cycle after the previous busy_end.
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));
    idleCheck("after_table");

    // Reset while waiting in RD_DATA with the slave withholding rvalid.
    $display("[TB] mid-read reset sequence");
    cfg_ar_dly = 0; cfg_r_dly = 1000; cfg_resp = 2'b00; cfg_rdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk); #2;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000_0060;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #2;
      mem_req = 1'b0;
      #1;
      if (bus.rready_o) seen = 1'b1;
    end
    checkOutput("rst_reached_rdata", {63'd0, seen}, 64'd1);
    rst = 1'b1;
    @(negedge clk); #3;
    checkOutput("rst_valids", {59'd0, bus.arvalid_o, bus.rready_o, bus.awvalid_o, bus.wvalid_o, bus.bready_o}, 64'd0);
    checkOutput("rst_busy", {62'd0, busy, busy_end}, 64'd0);
    checkOutput("rst_rdata", mem_rdata, 64'd0);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #3;
      if (busy_end || busy) pulses++;
    end
    checkOutput("rst_no_completion", 64'(pulses), 64'd0);
    prev_held = '0;
    applyStimulus(vecs[6], "v6_after_rst");
    idleCheck("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
